head_concat: RTL and testbench
==============================

# head_concat

Reassembles a full attention-head matrix from the per-group slices emitted by the split stage, giving the reverse of the split transform. Accepts one head-group slice per handshake and writes it into its position in an internal assembly buffer. When all groups have arrived, it presents the complete matrix and holds it until the consumer acknowledges. Sits between the per-head compute stages and the downstream projection/linear stage in the op_trans datapath.

## Interface
- DATA_WIDTH, 8, element width in bits
- SEQ_LEN, 128, rows per head (sequence length)
- SLICE_HEADS, 4, heads carried per slice; tunable by DSE
- HEAD_DIM, 64, columns per head
- HEAD_NUM, 12, total heads; HEAD_NUM % SLICE_HEADS must be 0, otherwise elaboration fails
- Derived: SLICE_W = DATA_WIDTH*SEQ_LEN*SLICE_HEADS*HEAD_DIM; SLICE_NUM = HEAD_NUM/SLICE_HEADS; IDX_W = max(1, clog2(SLICE_NUM))

Ports:
- clk_p  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- slice  in  SLICE_W  signed head-group slice
- slice_valid_n  in  1  active-low; slice is valid this cycle
- slice_first  in  1  marks slice as group 0 of a new matrix; only meaningful while slice_valid_n=0
- slice_ready  out  1  high when a slice can be accepted (registered)
- matrix  out  SLICE_W*SLICE_NUM  signed assembled matrix (registered)
- matrix_valid_n  out  1  active-low; matrix is complete and stable
- matrix_ack_n  in  1  active-low consumer acknowledge
- restart_err  out  1  one-cycle pulse when a partial matrix is abandoned

## Operation
- State machine has two states:
  - COLLECT: slice_ready=1, matrix_valid_n=1.
  - HOLD: slice_ready=0, matrix_valid_n=0.
- Accept event: rising edge with state=COLLECT and slice_valid_n=0.
- On an accept with slice_first=0, or with idx=0:
  - write slice to matrix[(idx+1)*SLICE_W-1 : idx*SLICE_W];
  - increment idx.
  - Group 0 occupies the LSBs, which matches the split ordering.
- On an accept with slice_first=1 and idx≠0:
  - the partial matrix is abandoned;
  - slice is written at group 0 and idx becomes 1;
  - restart_err pulses for one cycle;
  - stale upper groups stay in matrix and are overwritten as collection proceeds.
- On an accept with idx=SLICE_NUM-1 (and no restart): idx wraps to 0 and the state goes to HOLD.
  - Special case SLICE_NUM=1: every accept goes directly to HOLD.
- In HOLD:
  - slice_valid_n is ignored and no write occurs;
  - matrix stays frozen;
  - a rising edge with matrix_ack_n=0 moves the state to COLLECT with idx=0.
- matrix_ack_n is ignored in COLLECT.
- Reset values: state=COLLECT, idx=0, matrix=0, matrix_valid_n=1, slice_ready=1, restart_err=0.

## Timing
- Each slice is accepted in 1 cycle. Back-to-back slices are allowed, one per cycle.
- Assembly: matrix_valid_n falls on the edge that accepts the last slice, so it is visible in the following cycle. Minimum latency is SLICE_NUM cycles from the first accept.
- Acknowledge: matrix_valid_n rises and slice_ready rises on the same edge that samples the ack. The earliest next accept is the following edge, so ack and a new accept never share an edge.
- Reset asserted mid-collection or in HOLD: all state returns to reset values asynchronously. The partial matrix is discarded without a restart_err pulse.
- restart_err is registered. It is high for exactly the cycle after the offending accept.

## Structure
- The shared op_trans package holds:
  - the SLICE_W / SLICE_NUM / IDX_W derivation functions, shared with the split stage so both agree on slice layout;
  - the state enum {COLLECT, HOLD}.
- Single module, with no sub-module. The slice write is an indexed part-select write into the matrix register.

## Test plan
Bench parameters: DATA_WIDTH=8, SEQ_LEN=2, SLICE_HEADS=1, HEAD_DIM=2, HEAD_NUM=3, giving SLICE_W=32, SLICE_NUM=3, and a 96-bit matrix.
- Reset check: hold rst for 2 cycles, then release. Expect matrix=0, matrix_valid_n=1, slice_ready=1, restart_err=0.
- Back-to-back assembly: slices 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, with slice_first on the first. Next cycle: matrix=0x333333332222222211111111, matrix_valid_n=0, slice_ready=0.
- HOLD behaviour: drive slice 0xDEADBEEF with slice_valid_n=0 for 3 cycles while in HOLD and ack withheld. Expect matrix unchanged. Then ack for one cycle: next cycle matrix_valid_n=1, slice_ready=1, and a new slice is accepted at group 0.
- Restart: accept 0xAAAAAAAA and 0xBBBBBBBB, then 0xCCCCCCCC with slice_first=1. Expect restart_err pulse, low 32 bits = 0xCCCCCCCC, and two more slices required before matrix_valid_n=0.
- Reset mid-collection: assert rst after one accepted slice. Expect matrix=0 and idx=0 immediately. The following full 3-slice sequence assembles correctly.
- Gapped input: 3 slices separated by 4 idle cycles each. Expect matrix_valid_n=0 exactly one cycle after the third accept.

Source files
------------

// File: rtl/head_concat_pkg.sv
// Shared op_trans definitions: slice layout derivation used by split and
// concat stages so both agree on group ordering, plus the concat FSM states.
package head_concat_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } concat_state_e;

  function automatic int slice_w(input int data_width, input int seq_len,
                                 input int slice_heads, input int head_dim);
    return data_width * seq_len * slice_heads * head_dim;
  endfunction

  function automatic int slice_num(input int head_num, input int slice_heads);
    return head_num / slice_heads;
  endfunction

  // A single-group matrix still needs a 1-bit index register.
  function automatic int idx_w(input int n_slices);
    return (n_slices <= 1) ? 1 : $clog2(n_slices);
  endfunction

endpackage

// File: rtl/head_concat_if.sv
// Slice-in / matrix-out handshake bundle for head_concat.
// All valid/ack strobes are active-low.
interface head_concat_if #(
  parameter int SLICE_W   = 32,
  parameter int SLICE_NUM = 3
);
  logic signed [SLICE_W-1:0]           slice;
  logic                                slice_valid_n;
  logic                                slice_first;
  logic                                slice_ready;
  logic signed [SLICE_W*SLICE_NUM-1:0] matrix;
  logic                                matrix_valid_n;
  logic                                matrix_ack_n;
  logic                                restart_err;

  modport slave (
    input  slice, slice_valid_n, slice_first, matrix_ack_n,
    output slice_ready, matrix, matrix_valid_n, restart_err
  );

  modport master (
    output slice, slice_valid_n, slice_first, matrix_ack_n,
    input  slice_ready, matrix, matrix_valid_n, restart_err
  );
endinterface

// File: rtl/head_concat.sv
// Reassembles head-group slices into the full head matrix (inverse of split),
// group 0 in the LSBs, and holds the result until the consumer acks.
module head_concat
  import head_concat_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int SEQ_LEN     = 128,
  parameter int SLICE_HEADS = 4,
  parameter int HEAD_DIM    = 64,
  parameter int HEAD_NUM    = 12
) (
  input  logic          clk_p,
  input  logic          rst,
  head_concat_if.slave  bus
);

  localparam int SW = slice_w(DATA_WIDTH, SEQ_LEN, SLICE_HEADS, HEAD_DIM);
  localparam int SN = slice_num(HEAD_NUM, SLICE_HEADS);
  localparam int IW = idx_w(SN);
  localparam int MW = SW * SN;
  localparam logic [IW-1:0] LAST_IDX = IW'(SN - 1);

  if (HEAD_NUM % SLICE_HEADS != 0) begin : g_bad_cfg
    $error("head_concat: HEAD_NUM must be a multiple of SLICE_HEADS");
  end

  concat_state_e     state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [MW-1:0]     matrix_q, matrix_d;
  logic              ready_q, ready_d;
  logic              mvalid_n_q, mvalid_n_d;
  logic              restart_q, restart_d;

  logic              accept;
  logic              restart;
  logic [IW-1:0]     wr_idx;

  assign accept  = (state_q == COLLECT) && !bus.slice_valid_n;
  // A new first slice while a matrix is partially built abandons it.
  assign restart = accept && bus.slice_first && (idx_q != '0);
  assign wr_idx  = restart ? '0 : idx_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    matrix_d  = matrix_q;
    restart_d = 1'b0;

    unique case (state_q)
      COLLECT: begin
        if (accept) begin
          matrix_d[int'(wr_idx)*SW +: SW] = bus.slice;
          if (restart) begin
            idx_d     = IW'(1);
            restart_d = 1'b1;
          end else if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = HOLD;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end
      end
      HOLD: begin
        if (!bus.matrix_ack_n) begin
          state_d = COLLECT;
          idx_d   = '0;
        end
      end
      default: state_d = COLLECT;
    endcase

    // Outputs are registered copies of the next-state decode.
    ready_d    = (state_d == COLLECT);
    mvalid_n_d = (state_d != HOLD);
  end

  always_ff @(posedge clk_p or posedge rst) begin
    if (rst) begin
      state_q    <= COLLECT;
      idx_q      <= '0;
      matrix_q   <= '0;
      ready_q    <= 1'b1;
      mvalid_n_q <= 1'b1;
      restart_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      matrix_q   <= matrix_d;
      ready_q    <= ready_d;
      mvalid_n_q <= mvalid_n_d;
      restart_q  <= restart_d;
    end
  end

  assign bus.slice_ready    = ready_q;
  assign bus.matrix         = matrix_q;
  assign bus.matrix_valid_n = mvalid_n_q;
  assign bus.restart_err    = restart_q;

endmodule

// File: tb/tb_head_concat.sv
// Directed bench for head_concat: stimulus pushes expected matrices into a
// queue, a monitor pops and compares each time a matrix is presented.
module tb_head_concat;
  import head_concat_pkg::*;

  localparam int DW = 8, SEQ = 2, SH = 1, HD = 2, HN = 3;
  localparam int SW = 32, SN = 3, MW = 96;

  logic clk_p = 1'b0;
  logic rst   = 1'b1;
  always #5 clk_p = ~clk_p;

  head_concat_if #(.SLICE_W(SW), .SLICE_NUM(SN)) bus ();

  head_concat #(
    .DATA_WIDTH(DW), .SEQ_LEN(SEQ), .SLICE_HEADS(SH), .HEAD_DIM(HD), .HEAD_NUM(HN)
  ) dut (
    .clk_p (clk_p),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int tests = 0;
  int fails = 0;
  logic [MW-1:0] exp_q[$];
  logic          done = 1'b0;

  task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk_p);
    @(negedge clk_p);
  endtask

  task automatic drive(input logic [SW-1:0] s, input logic vn, input logic first);
    bus.slice         = s;
    bus.slice_valid_n = vn;
    bus.slice_first   = first;
  endtask

  task automatic ack();
    drive('0, 1'b1, 1'b0);
    bus.matrix_ack_n = 1'b0;
    step();
    bus.matrix_ack_n = 1'b1;
  endtask

  // Monitor: pop on each new matrix presentation, then verify it stays frozen.
  initial begin
    logic          prev_vn;
    logic [MW-1:0] cur;
    prev_vn = 1'b1;
    cur     = '0;
    forever begin
      @(negedge clk_p);
      if (done) break;
      if (!rst) begin
        if (!bus.matrix_valid_n && prev_vn) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_matrix: got %h expected none", bus.matrix);
          end else begin
            cur = exp_q.pop_front();
            chk("matrix", bus.matrix, cur);
          end
        end else if (!bus.matrix_valid_n) begin
          chk("hold_stable", bus.matrix, cur);
        end
        prev_vn = bus.matrix_valid_n;
      end else begin
        prev_vn = 1'b1;
      end
    end
  end

  initial begin
    drive('0, 1'b1, 1'b0);
    bus.matrix_ack_n = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk_p);
    @(negedge clk_p);
    rst = 1'b0;

    // Reset state
    chk("rst_matrix", bus.matrix, '0);
    chk("rst_valid_n", MW'(bus.matrix_valid_n), MW'(1));
    chk("rst_ready", MW'(bus.slice_ready), MW'(1));
    chk("rst_restart", MW'(bus.restart_err), MW'(0));

    // Back-to-back assembly
    exp_q.push_back(96'h33333333_22222222_11111111);
    drive(32'h11111111, 1'b0, 1'b1); step();
    drive(32'h22222222, 1'b0, 1'b0); step();
    drive(32'h33333333, 1'b0, 1'b0); step();
    chk("b2b_valid_n", MW'(bus.matrix_valid_n), MW'(0));
    chk("b2b_ready", MW'(bus.slice_ready), MW'(0));

    // HOLD ignores slices; ack reopens collection
    drive(32'hDEADBEEF, 1'b0, 1'b0);
    repeat (3) step();
    chk("hold_matrix", bus.matrix, 96'h33333333_22222222_11111111);
    bus.matrix_ack_n = 1'b0;
    step();
    bus.matrix_ack_n = 1'b1;
    chk("ack_valid_n", MW'(bus.matrix_valid_n), MW'(1));
    chk("ack_ready", MW'(bus.slice_ready), MW'(1));
    step();
    chk("post_ack_g0", MW'(bus.matrix[31:0]), MW'(32'hDEADBEEF));
    exp_q.push_back(96'h55555555_44444444_DEADBEEF);
    drive(32'h44444444, 1'b0, 1'b0); step();
    drive(32'h55555555, 1'b0, 1'b0); step();
    ack();

    // Restart abandons the partial matrix
    drive(32'hAAAAAAAA, 1'b0, 1'b1); step();
    chk("first_no_restart", MW'(bus.restart_err), MW'(0));
    drive(32'hBBBBBBBB, 1'b0, 1'b0); step();
    drive(32'hCCCCCCCC, 1'b0, 1'b1); step();
    chk("restart_pulse", MW'(bus.restart_err), MW'(1));
    chk("restart_g0", MW'(bus.matrix[31:0]), MW'(32'hCCCCCCCC));
    chk("restart_valid_n", MW'(bus.matrix_valid_n), MW'(1));
    exp_q.push_back(96'hEEEEEEEE_DDDDDDDD_CCCCCCCC);
    drive(32'hDDDDDDDD, 1'b0, 1'b0); step();
    chk("restart_pulse_end", MW'(bus.restart_err), MW'(0));
    chk("restart_need2", MW'(bus.matrix_valid_n), MW'(1));
    drive(32'hEEEEEEEE, 1'b0, 1'b0); step();
    chk("restart_done", MW'(bus.matrix_valid_n), MW'(0));
    ack();

    // Reset mid-collection
    drive(32'h12345678, 1'b0, 1'b1); step();
    drive('0, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_matrix", bus.matrix, '0);
    chk("mid_rst_ready", MW'(bus.slice_ready), MW'(1));
    chk("mid_rst_restart", MW'(bus.restart_err), MW'(0));
    step();
    rst = 1'b0;
    exp_q.push_back(96'h0C0C0C0C_0B0B0B0B_0A0A0A0A);
    drive(32'h0A0A0A0A, 1'b0, 1'b0); step();
    drive(32'h0B0B0B0B, 1'b0, 1'b0); step();
    drive(32'h0C0C0C0C, 1'b0, 1'b0); step();
    chk("post_rst_valid_n", MW'(bus.matrix_valid_n), MW'(0));
    ack();

    // Gapped input
    exp_q.push_back(96'h76543210_FEDCBA98_01234567);
    drive(32'h01234567, 1'b0, 1'b1); step();
    drive('0, 1'b1, 1'b0); repeat (4) step();
    drive(32'hFEDCBA98, 1'b0, 1'b0); step();
    drive('0, 1'b1, 1'b0); repeat (4) step();
    chk("gap_not_early", MW'(bus.matrix_valid_n), MW'(1));
    drive(32'h76543210, 1'b0, 1'b0); step();
    chk("gap_valid_n", MW'(bus.matrix_valid_n), MW'(0));
    ack();

    step();
    chk("scoreboard_empty", MW'(exp_q.size()), MW'(0));
    done = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
